// File: rtl/div_seq_ctrl_pkg.sv
// rtl/div_seq_ctrl_pkg.sv - shared state encoding and width default for the divide sequencer
package div_seq_ctrl_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_step.sv
// rtl/div_seq_ctrl_step.sv - one radix-2 restoring divide step
// A W+1-bit trial subtract; a borrow keeps the shifted remainder and yields a 0 quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;

    assign trial = {rem_i, dvd_msb_i} - {1'b0, dvs_i};
    assign q_o   = ~trial[WIDTH];
    // rem < dvs on entry, so the shifted value fits WIDTH bits whenever a borrow occurs
    assign rem_o = trial[WIDTH] ? {rem_i[WIDTH-2:0], dvd_msb_i} : trial[WIDTH-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle DIV/DIVU sequencer that stalls EX until {remainder, quotient} is ready
// Magnitudes are divided unsigned; signs are reapplied combinationally in the FINISH cycle.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int               WIDTH     = DIV_WIDTH,
    parameter logic [WIDTH-1:0] DIVZERO_Q = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic               div_cancel,
    input  logic [WIDTH-1:0]   div_src1,
    input  logic [WIDTH-1:0]   div_src2,
    output logic               stallreq_for_div,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] div_result
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    div_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               sign_q_q;
    logic               sign_r_q;
    logic [2*WIDTH-1:0] div_result_q;

    logic [WIDTH-1:0]   rem_d;
    logic               qbit_d;
    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   final_rem;
    logic [WIDTH-1:0]   final_quo;
    logic               finish_ok;

    assign s1   = div_signed & div_src1[WIDTH-1];
    assign s2   = div_signed & div_src2[WIDTH-1];
    assign mag1 = s1 ? (-div_src1) : div_src1;
    assign mag2 = s2 ? (-div_src2) : div_src2;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (rem_d),
        .q_o       (qbit_d)
    );

    assign final_rem = sign_r_q ? (-rem_q) : rem_q;
    assign final_quo = sign_q_q ? (-quo_q) : quo_q;

    // A flush in the FINISH cycle must swallow the result, so ready and the live result track div_cancel
    assign finish_ok        = (state_q == DIV_END) & ~div_cancel;
    assign div_ready        = finish_ok;
    assign div_result       = finish_ok ? {final_rem, final_quo} : div_result_q;
    assign stallreq_for_div = ~div_cancel & (((state_q == DIV_IDLE) & div_start) |
                                             (state_q == DIV_BYZERO) | (state_q == DIV_ON));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DIV_IDLE;
            cnt_q        <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            sign_q_q     <= 1'b0;
            sign_r_q     <= 1'b0;
            div_result_q <= '0;
        end else if (div_cancel) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_start) begin
                        if (div_src2 == '0) begin
                            // Preload the divide-by-zero answer so FINISH needs no special case
                            state_q  <= DIV_BYZERO;
                            rem_q    <= div_src1;
                            quo_q    <= DIVZERO_Q;
                            sign_q_q <= 1'b0;
                            sign_r_q <= 1'b0;
                        end else begin
                            state_q  <= DIV_ON;
                            dvd_q    <= mag1;
                            dvs_q    <= mag2;
                            rem_q    <= '0;
                            quo_q    <= '0;
                            cnt_q    <= '0;
                            sign_q_q <= s1 ^ s2;
                            sign_r_q <= s1;
                        end
                    end
                end
                DIV_BYZERO: begin
                    state_q <= DIV_END;
                end
                DIV_ON: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[WIDTH-2:0], qbit_d};
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DIV_END;
                    end
                end
                DIV_END: begin
                    div_result_q <= {final_rem, final_quo};
                    state_q      <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - directed self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic        div_cancel;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        stallreq_for_div;
    logic        div_ready;
    logic [63:0] div_result;

    int checks;
    int failures;

    div_seq_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .div_start        (div_start),
        .div_signed       (div_signed),
        .div_cancel       (div_cancel),
        .div_src1         (div_src1),
        .div_src2         (div_src2),
        .stallreq_for_div (stallreq_for_div),
        .div_ready        (div_ready),
        .div_result       (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered #1 after a posedge; cycle 0 is the cycle div_start first goes high.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input bit toggle,
                          output int rdy_cyc, output int stall_cnt, output int rdy_cnt,
                          output logic stall_cancel, output logic [63:0] rdy_res,
                          output logic [63:0] end_res);
        rdy_cyc      = -1;
        stall_cnt    = 0;
        rdy_cnt      = 0;
        stall_cancel = 1'bx;
        rdy_res      = 'x;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin
                div_signed = sg;
                div_src1   = a;
                div_src2   = b;
                div_start  = 1'b1;
            end
            if (toggle && c >= 5 && c <= 20) begin
                div_start = c[0];
                div_src1  = 32'h1234_5678 ^ c;
                div_src2  = 32'h0000_0001;
            end
            div_cancel = (c == cancel_at);
            if (c == cancel_at) div_start = 1'b0;
            @(negedge clk);
            if (c == cancel_at) stall_cancel = stallreq_for_div;
            if (stallreq_for_div) stall_cnt++;
            if (div_ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    rdy_res = div_result;
                end
                div_start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        div_cancel = 1'b0;
        div_start  = 1'b0;
        @(negedge clk);
        end_res = div_result;
        @(posedge clk);
        #1;
    endtask

    task automatic op_check(input string tag, input logic sg, input logic [31:0] a,
                            input logic [31:0] b, input bit toggle, input logic [63:0] exp_res,
                            input int exp_cyc, input int exp_stall);
        int rc, sc, nc;
        logic stc;
        logic [63:0] rr, er;
        run_op(sg, a, b, -1, toggle, rc, sc, nc, stc, rr, er);
        chk({tag, "_ready_cycle"}, 64'(rc), 64'(exp_cyc));
        chk({tag, "_stall_cycles"}, 64'(sc), 64'(exp_stall));
        chk({tag, "_ready_pulses"}, 64'(nc), 64'd1);
        chk({tag, "_result"}, rr, exp_res);
        chk({tag, "_result_hold"}, er, exp_res);
    endtask

    initial begin
        int rc, sc, nc;
        logic stc;
        logic [63:0] rr, er;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_cancel = 1'b0;
        div_src1   = '0;
        div_src2   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 64'(stallreq_for_div), 64'd0);
        chk("reset_ready", 64'(div_ready), 64'd0);
        chk("reset_result", div_result, 64'd0);
        @(posedge clk);
        #1;

        op_check("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 33);
        op_check("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0,
                 {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33);
        op_check("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
                 {32'h0, 32'h8000_0000}, 33, 33);
        op_check("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
                 {32'h8000_0000, 32'h0}, 33, 33);
        op_check("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0, {32'h5, 32'hFFFF_FFFF}, 2, 2);
        op_check("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0,
                 {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 2, 2);

        // Flush during iteration 10 (cycle 11) of 1000/3
        run_op(1'b0, 32'd1000, 32'd3, 11, 1'b0, rc, sc, nc, stc, rr, er);
        chk("cancel_on_stall", 64'(stc), 64'd0);
        chk("cancel_on_ready_pulses", 64'(nc), 64'd0);
        chk("cancel_on_stall_cycles", 64'(sc), 64'd11);
        chk("cancel_on_result_hold", er, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        op_check("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 33);

        op_check("toggle_1000_3", 1'b0, 32'd1000, 32'd3, 1'b1, {32'd1, 32'd333}, 33, 33);

        // Flush in the FINISH cycle of 20/-6
        run_op(1'b1, 32'd20, 32'hFFFF_FFFA, 33, 1'b0, rc, sc, nc, stc, rr, er);
        chk("cancel_fin_ready_pulses", 64'(nc), 64'd0);
        chk("cancel_fin_stall_cycles", 64'(sc), 64'd33);
        chk("cancel_fin_result_hold", er, {32'd1, 32'd333});
        op_check("div_20_m6", 1'b1, 32'd20, 32'hFFFF_FFFA, 1'b0,
                 {32'd2, 32'hFFFF_FFFD}, 33, 33);

        // Reset in the middle of ON
        div_signed = 1'b0;
        div_src1   = 32'd1000;
        div_src2   = 32'd3;
        div_start  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst       = 1'b1;
        div_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_on_stall", 64'(stallreq_for_div), 64'd0);
        chk("rst_on_ready", 64'(div_ready), 64'd0);
        chk("rst_on_result", div_result, 64'd0);
        nc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_ready) nc++;
        end
        chk("rst_on_no_ready", 64'(nc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
